// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit engine between NUM_REQ byte producers.
// Each granted byte is issued to the engine, tracked to tx_done, then followed by an idle gap.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_BITS  = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_start,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_busy,
   input  logic                           tx_done,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           active
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
   logic [IDX_W-1:0]     grant_id_q, grant_id_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     scan_idx;
   logic [DATA_BITS-1:0] win_data;

   // Scan starts just after the last grant, so the previous winner is checked last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_data = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      gap_cnt_d  = gap_cnt_q;
      req_ready  = '0;
      tx_start   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               req_ready[win_idx] = 1'b1;
               tx_data_d          = win_data;
               grant_id_d         = win_idx;
               last_d             = win_idx;
               state_d            = ST_ISSUE;
            end
         end
         // tx_done arriving here belongs to no frame of ours and is ignored.
         ST_ISSUE: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               if (GAP_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_cnt_d = GAP_LOAD;
                  state_d   = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tx_data_q  <= '0;
         grant_id_q <= '0;
         last_q     <= LAST_RST;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign grant_id = grant_id_q;
   assign active   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a GAP_CYCLES=2 instance checked through a frame scoreboard,
// plus a GAP_CYCLES=0 instance for back-to-back timing.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DB = 8;

   logic            clk;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [NR*DB-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            tx_start;
   logic [DB-1:0]   tx_data;
   logic            tx_busy;
   logic            tx_done;
   logic [1:0]      grant_id;
   logic            active;

   logic [NR-1:0]   r0_valid;
   logic [NR*DB-1:0] r0_data;
   logic [NR-1:0]   r0_ready;
   logic            tx0_start;
   logic [DB-1:0]   tx0_data;
   logic            tx0_busy;
   logic            tx0_done;
   logic [1:0]      grant0_id;
   logic            active0;

   int checks;
   int errors;
   int start_cnt;
   int done_delay;
   logic eng_auto;
   logic [9:0] exp_q[$];
   logic [9:0] mon_item;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .active(active)
   );

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(r0_valid), .req_data(r0_data),
      .req_ready(r0_ready), .tx_start(tx0_start), .tx_data(tx0_data),
      .tx_busy(tx0_busy), .tx_done(tx0_done), .grant_id(grant0_id), .active(active0)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks; inputs change 1 time unit after a falling edge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100; n++) begin
         if (!active) break;
         step();
      end
      check_eq("idle_timeout", 32'(active), 0);
   endtask

   task automatic issue_one(input logic [NR-1:0] valid, input int exp_id);
      logic [NR-1:0] onehot;
      for (int i = 0; i < NR; i++) req_data[i*DB +: DB] = 8'($urandom_range(0, 255));
      onehot = '0;
      onehot[exp_id] = 1'b1;
      req_valid = valid;
      #1;
      check_eq("rr_ready", 32'(req_ready), 32'(onehot));
      exp_q.push_back({2'(exp_id), req_data[exp_id*DB +: DB]});
      step();
      req_valid = '0;
      wait_idle();
   endtask

   // tx engine model: tx_done pulse done_delay cycles after each tx_start
   initial begin
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && tx_start && eng_auto) begin
            repeat (done_delay) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   // scoreboard: every tx_start pops one expected {grant_id, tx_data}
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && tx_start) begin
            start_cnt++;
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_item = exp_q.pop_front();
               check_eq("sb_frame", 32'({grant_id, tx_data}), 32'(mon_item));
            end
         end
      end
   end

   initial begin
      int base;
      checks = 0; errors = 0; start_cnt = 0;
      done_delay = 8; eng_auto = 1'b1;
      reset = 1'b1;
      req_valid = '0; req_data = '0; tx_busy = 1'b0;
      r0_valid = '0; r0_data = '0; tx0_busy = 1'b0; tx0_done = 1'b0;
      step();
      step();
      check_eq("rst_ready", 32'(req_ready), 0);
      check_eq("rst_start", 32'(tx_start), 0);
      check_eq("rst_data", 32'(tx_data), 0);
      check_eq("rst_grant", 32'(grant_id), 0);
      check_eq("rst_active", 32'(active), 0);
      check_eq("rst0_active", 32'(active0), 0);
      reset = 1'b0;
      step();

      // single request, tx_done 10 cycles after accept
      done_delay = 9;
      req_data[2*DB +: DB] = 8'hA5;
      req_valid = 4'b0100;
      #1;
      check_eq("single_ready", 32'(req_ready), 32'b0100);
      exp_q.push_back({2'd2, 8'hA5});
      step();
      req_valid = '0;
      check_eq("single_start", 32'(tx_start), 1);
      check_eq("single_data", 32'(tx_data), 32'hA5);
      check_eq("single_grant", 32'(grant_id), 2);
      repeat (10) step();
      req_valid = 4'b0001;
      #1;
      check_eq("gap_ready_lo", 32'(req_ready), 0);
      step();
      check_eq("gap_active", 32'(active), 1);
      check_eq("gap_ready_lo2", 32'(req_ready), 0);
      step();
      check_eq("gap_end_active", 32'(active), 0);
      check_eq("gap_end_ready", 32'(req_ready), 32'b0001);
      req_valid = '0;
      step();
      check_eq("drop_no_accept", 32'(active), 0);
      check_eq("hold_grant", 32'(grant_id), 2);
      check_eq("hold_data", 32'(tx_data), 32'hA5);

      // all requesters valid: order 0,1,2,3,0
      done_delay = 8;
      do_reset();
      for (int i = 0; i < NR; i++) req_data[i*DB +: DB] = 8'(8'h10 + i);
      base = start_cnt;
      for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % NR), 8'(8'h10 + (i % NR))});
      req_valid = 4'b1111;
      for (int n = 0; n < 200; n++) begin
         if (start_cnt >= base + 5) break;
         step();
      end
      req_valid = '0;
      check_eq("all_starts_seen", 32'(start_cnt - base), 5);
      wait_idle();
      check_eq("all_start_count", 32'(start_cnt - base), 5);

      // priority rotation
      issue_one(4'b0010, 1);
      issue_one(4'b0011, 0);
      issue_one(4'b0011, 1);

      // engine busy for 5 cycles after accept (last grant 1, scan 2 first)
      tx_busy = 1'b1;
      req_data[2*DB +: DB] = 8'h3C;
      req_valid = 4'b0100;
      #1;
      check_eq("busy_ready", 32'(req_ready), 32'b0100);
      exp_q.push_back({2'd2, 8'h3C});
      step();
      req_valid = '0;
      base = start_cnt;
      for (int k = 0; k < 5; k++) begin
         check_eq("busy_no_start", 32'(tx_start), 0);
         check_eq("busy_data", 32'(tx_data), 32'h3C);
         if (k < 4) step();
      end
      @(posedge clk);
      #1 tx_busy = 1'b0;
      step();
      check_eq("busy_start", 32'(tx_start), 1);
      check_eq("busy_data_kept", 32'(tx_data), 32'h3C);
      step();
      check_eq("busy_single_start", 32'(start_cnt - base), 1);
      wait_idle();

      // reset while waiting for tx_done
      eng_auto = 1'b0;
      req_data[1*DB +: DB] = 8'($urandom_range(0, 255));
      req_valid = 4'b0010;
      #1;
      check_eq("mid_ready", 32'(req_ready), 32'b0010);
      exp_q.push_back({2'd1, req_data[1*DB +: DB]});
      step();
      req_valid = '0;
      step();
      step();
      check_eq("mid_stall_active", 32'(active), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("mid_rst_active", 32'(active), 0);
      check_eq("mid_rst_data", 32'(tx_data), 0);
      check_eq("mid_rst_grant", 32'(grant_id), 0);
      eng_auto = 1'b1;
      issue_one(4'b1001, 0);

      // GAP_CYCLES=0 instance: next accept right after tx_done
      r0_data[1*DB +: DB] = 8'h5A;
      r0_valid = 4'b0010;
      #1;
      check_eq("g0_ready", 32'(r0_ready), 32'b0010);
      step();
      check_eq("g0_start", 32'(tx0_start), 1);
      check_eq("g0_data", 32'(tx0_data), 32'h5A);
      check_eq("g0_grant", 32'(grant0_id), 1);
      step();
      tx0_done = 1'b1;
      #1;
      check_eq("g0_wait_ready", 32'(r0_ready), 0);
      step();
      tx0_done = 1'b0;
      #1;
      check_eq("g0_reaccept_ready", 32'(r0_ready), 32'b0010);
      check_eq("g0_idle", 32'(active0), 0);
      step();
      r0_valid = '0;
      check_eq("g0_restart", 32'(tx0_start), 1);
      step();
      tx0_done = 1'b1;
      step();
      tx0_done = 1'b0;
      check_eq("g0_final_idle", 32'(active0), 0);

      check_eq("sb_drain", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
